// File: rtl/spi_sram_pkg.sv
// Shared command codes and slave FSM states for the SPI serial-SRAM responder.
package spi_sram_pkg;

    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_WRITE = 8'h02;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR_HI,
        ADDR_LO,
        READ_DATA,
        WRITE_DATA,
        IGNORE
    } spi_slv_state_t;

endpackage

// File: rtl/spi_sram_array.sv
// Byte storage: one synchronous write port, two combinational read ports.
module spi_sram_array #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [7:0]        rdata_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [7:0]        rdata_b
);

    logic [7:0] mem_q [0:(2**ADDR_W)-1];

    // Contents deliberately survive reset so preloaded programs are kept.
    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata_a = mem_q[raddr_a];
    assign rdata_b = mem_q[raddr_b];

endmodule

// File: rtl/spi_sram_responder.sv
// SPI mode-0 slave emulating a 23LC512-style serial SRAM (READ 0x03 / WRITE 0x02).
// Define SPI_SRAM_SEQ_EN for sequential streaming; otherwise one data byte per transaction.
module spi_sram_responder
    import spi_sram_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              spi_cs_n,
    input  logic              spi_sclk,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              busy,
    input  logic              bd_we,
    input  logic [ADDR_W-1:0] bd_addr,
    input  logic [7:0]        bd_wdata,
    output logic [7:0]        bd_rdata
);

    spi_slv_state_t    state_q, state_d;
    logic              sclk_q;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        rx_shift_q, rx_shift_d;
    logic [7:0]        tx_shift_q, tx_shift_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              is_rd_q, is_rd_d;

    logic              rise, byte_done;
    logic [7:0]        rx_byte;
    logic              spi_we, bd_ok, mem_we;
    logic [ADDR_W-1:0] spi_raddr, mem_waddr;
    logic [7:0]        spi_rdata, mem_wdata;

    assign rise      = ~spi_cs_n & spi_sclk & ~sclk_q;
    assign byte_done = rise && (bit_cnt_q == 3'd7);
    assign rx_byte   = {rx_shift_q[6:0], spi_mosi};

    assign busy     = (state_q != IDLE);
    assign spi_miso = (state_q == READ_DATA) ? tx_shift_q[7] : 1'b0;

    // Backdoor only gets the port while the link is fully quiet.
    assign bd_ok     = bd_we & spi_cs_n & (state_q == IDLE);
    assign mem_we    = spi_we | bd_ok;
    assign mem_waddr = spi_we ? addr_q : bd_addr;
    assign mem_wdata = spi_we ? rx_byte : bd_wdata;

    spi_sram_array #(.ADDR_W(ADDR_W)) u_array (
        .clk     (clk),
        .we      (mem_we),
        .waddr   (mem_waddr),
        .wdata   (mem_wdata),
        .raddr_a (spi_raddr),
        .rdata_a (spi_rdata),
        .raddr_b (bd_addr),
        .rdata_b (bd_rdata)
    );

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_shift_d = rx_shift_q;
        tx_shift_d = tx_shift_q;
        addr_d     = addr_q;
        is_rd_d    = is_rd_q;
        spi_we     = 1'b0;
        spi_raddr  = addr_q + ADDR_W'(1);
        if (spi_cs_n) begin
            state_d    = IDLE;
            bit_cnt_d  = 3'd0;
            tx_shift_d = 8'h00;
        end else begin
            if (rise) begin
                rx_shift_d = rx_byte;
                bit_cnt_d  = bit_cnt_q + 3'd1;
            end
            case (state_q)
                IDLE: state_d = CMD;
                CMD: if (byte_done) begin
                    if (rx_byte == CMD_READ) begin
                        is_rd_d = 1'b1;
                        state_d = ADDR_HI;
                    end else if (rx_byte == CMD_WRITE) begin
                        is_rd_d = 1'b0;
                        state_d = ADDR_HI;
                    end else begin
                        state_d = IGNORE;
                    end
                end
                ADDR_HI: if (byte_done) state_d = ADDR_LO;
                ADDR_LO: if (byte_done) begin
                    addr_d    = rx_byte[ADDR_W-1:0];
                    spi_raddr = rx_byte[ADDR_W-1:0];
                    if (is_rd_q) begin
                        tx_shift_d = spi_rdata;
                        state_d    = READ_DATA;
                    end else begin
                        state_d = WRITE_DATA;
                    end
                end
                READ_DATA: begin
                    // Shift after the master's sample edge; next bit settles one clk later.
                    if (rise) tx_shift_d = {tx_shift_q[6:0], 1'b0};
                    if (byte_done) begin
                        addr_d     = addr_q + ADDR_W'(1);
                        tx_shift_d = spi_rdata;
`ifndef SPI_SRAM_SEQ_EN
                        state_d    = IGNORE;
`endif
                    end
                end
                WRITE_DATA: if (byte_done) begin
                    spi_we = 1'b1;
                    addr_d = addr_q + ADDR_W'(1);
`ifndef SPI_SRAM_SEQ_EN
                    state_d = IGNORE;
`endif
                end
                IGNORE:  state_d = IGNORE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            sclk_q     <= 1'b0;
            bit_cnt_q  <= 3'd0;
            rx_shift_q <= 8'h00;
            tx_shift_q <= 8'h00;
            addr_q     <= '0;
            is_rd_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            sclk_q     <= spi_sclk;
            bit_cnt_q  <= bit_cnt_d;
            rx_shift_q <= rx_shift_d;
            tx_shift_q <= tx_shift_d;
            addr_q     <= addr_d;
            is_rd_q    <= is_rd_d;
        end
    end

endmodule

// File: tb/tb_spi_sram_responder.sv
// Directed bench for spi_sram_responder: SPI master at clk/2 plus backdoor checks.
module tb_spi_sram_responder;

    logic       clk = 1'b0;
    logic       reset;
    logic       spi_cs_n, spi_sclk, spi_mosi;
    logic       spi_miso, busy;
    logic       bd_we;
    logic [7:0] bd_addr, bd_wdata, bd_rdata;

    int n_cmp = 0;
    int n_err = 0;

    spi_sram_responder #(.ADDR_W(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .spi_cs_n (spi_cs_n),
        .spi_sclk (spi_sclk),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso),
        .busy     (busy),
        .bd_we    (bd_we),
        .bd_addr  (bd_addr),
        .bd_wdata (bd_wdata),
        .bd_rdata (bd_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic spi_bit(input logic b, output logic r);
        spi_mosi = b;
        spi_sclk = 1'b0;
        tick();
        spi_sclk = 1'b1;
        r = spi_miso;
        tick();
        spi_sclk = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(tx[i], r);
            rx[i] = r;
        end
    endtask

    task automatic cs_start();
        spi_sclk = 1'b0;
        spi_cs_n = 1'b0;
        tick();
    endtask

    task automatic cs_end();
        spi_sclk = 1'b0;
        tick();
        spi_cs_n = 1'b1;
        tick();
        tick();
    endtask

    task automatic spi_write(input logic [15:0] a, input logic [7:0] d);
        logic [7:0] r;
        cs_start();
        spi_byte(8'h02, r);
        spi_byte(a[15:8], r);
        spi_byte(a[7:0], r);
        spi_byte(d, r);
        cs_end();
    endtask

    task automatic spi_read(input logic [15:0] a, output logic [7:0] d);
        logic [7:0] r;
        cs_start();
        spi_byte(8'h03, r);
        spi_byte(a[15:8], r);
        spi_byte(a[7:0], r);
        spi_byte(8'h00, d);
        cs_end();
    endtask

    task automatic bd_wr(input logic [7:0] a, input logic [7:0] d);
        bd_addr  = a;
        bd_wdata = d;
        bd_we    = 1'b1;
        tick();
        bd_we    = 1'b0;
    endtask

    task automatic bd_rd(input logic [7:0] a, output logic [7:0] d);
        bd_addr = a;
        #1;
        d = bd_rdata;
    endtask

    initial begin
        logic [7:0] r, r2, acc, d;
        logic       b;
        reset = 1'b1; spi_cs_n = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0;
        bd_we = 1'b0; bd_addr = 8'h00; bd_wdata = 8'h00;
        tick(); tick();
        chk("rst_miso", {15'b0, spi_miso}, 16'h0);
        chk("rst_busy", {15'b0, busy}, 16'h0);
        #2 reset = 1'b0;
        tick();

        // SPI write then read-back
        cs_start();
        spi_byte(8'h02, r);
        chk("busy_in_xfer", {15'b0, busy}, 16'h1);
        spi_byte(8'h00, r);
        spi_byte(8'h10, r);
        spi_byte(8'h5A, r);
        cs_end();
        bd_rd(8'h10, d);
        chk("bd_after_wr", {8'h0, d}, 16'h005A);
        spi_read(16'h0010, r);
        chk("rd_0010", {8'h0, r}, 16'h005A);

        // high address byte ignored
        bd_wr(8'hFF, 8'h42);
        bd_rd(8'hFF, d);
        chk("bd_preload", {8'h0, d}, 16'h0042);
        spi_read(16'h12FF, r);
        chk("rd_12FF", {8'h0, r}, 16'h0042);

        // two-byte read across the wrap point
        bd_wr(8'hFF, 8'hA1);
        bd_wr(8'h00, 8'hB2);
        cs_start();
        spi_byte(8'h03, r);
        spi_byte(8'h00, r);
        spi_byte(8'hFF, r);
        spi_byte(8'h00, r);
        spi_byte(8'h00, r2);
        cs_end();
        chk("wrap_b0", {8'h0, r}, 16'h00A1);
`ifdef SPI_SRAM_SEQ_EN
        chk("wrap_b1", {8'h0, r2}, 16'h00B2);
`else
        chk("wrap_b1", {8'h0, r2}, 16'h0000);
`endif

        // unknown command: silent, no memory effect
        cs_start();
        spi_byte(8'h9F, r);
        acc = 8'h00;
        for (int k = 0; k < 3; k++) begin
            spi_byte(8'hFF, r);
            acc = acc | r;
        end
        chk("ign_busy", {15'b0, busy}, 16'h1);
        chk("ign_miso", {8'h0, acc}, 16'h0000);
        cs_end();
        chk("ign_busy_drop", {15'b0, busy}, 16'h0);
        bd_rd(8'hFF, d);
        chk("ign_memFF", {8'h0, d}, 16'h00A1);
        bd_rd(8'h10, d);
        chk("ign_mem10", {8'h0, d}, 16'h005A);

        // CS abort mid data byte; backdoor blocked while busy
        bd_wr(8'h20, 8'h33);
        bd_wr(8'h30, 8'h00);
        cs_start();
        spi_byte(8'h02, r);
        spi_byte(8'h00, r);
        spi_byte(8'h20, r);
        bd_wr(8'h30, 8'h77);
        for (int k = 0; k < 4; k++) spi_bit(1'b1, b);
        cs_end();
        chk("abort_busy", {15'b0, busy}, 16'h0);
        bd_rd(8'h20, d);
        chk("abort_mem20", {8'h0, d}, 16'h0033);
        bd_rd(8'h30, d);
        chk("bd_blocked", {8'h0, d}, 16'h0000);
        bd_wr(8'h30, 8'h77);
        bd_rd(8'h30, d);
        chk("bd_idle_wr", {8'h0, d}, 16'h0077);

        // multi-byte write: second byte lands only in sequential mode
        bd_wr(8'h41, 8'h00);
        cs_start();
        spi_byte(8'h02, r);
        spi_byte(8'h00, r);
        spi_byte(8'h40, r);
        spi_byte(8'h11, r);
        spi_byte(8'h22, r);
        cs_end();
        bd_rd(8'h40, d);
        chk("mw_40", {8'h0, d}, 16'h0011);
        bd_rd(8'h41, d);
`ifdef SPI_SRAM_SEQ_EN
        chk("mw_41", {8'h0, d}, 16'h0022);
`else
        chk("mw_41", {8'h0, d}, 16'h0000);
`endif

        // async reset in the middle of a read data phase
        cs_start();
        spi_byte(8'h03, r);
        spi_byte(8'h00, r);
        spi_byte(8'h10, r);
        spi_bit(1'b0, b);
        tick();
        chk("pre_rst_miso", {15'b0, spi_miso}, 16'h1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_miso", {15'b0, spi_miso}, 16'h0);
        chk("async_rst_busy", {15'b0, busy}, 16'h0);
        spi_cs_n = 1'b1;
        spi_sclk = 1'b0;
        tick();
        #2 reset = 1'b0;
        tick();
        bd_rd(8'h10, d);
        chk("rst_mem_kept", {8'h0, d}, 16'h005A);
        spi_read(16'h0010, r);
        chk("rd_after_rst", {8'h0, r}, 16'h005A);

        // controller-style round trips
        for (int i = 0; i < 8; i++) begin
            logic [7:0] a, v;
            a = 8'h80 + 8'(i);
            v = 8'(i * 29 + 3);
            spi_write({8'h00, a}, v);
            spi_read({8'h00, a}, r);
            chk("round_trip", {a, r}, {a, v});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
